// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel clock-enable divider, h/v counters, sync/blank decodes,
// line/frame strobes and a once-per-frame CPU interrupt latch with acknowledge.
module video_timing_gen #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned HW            = 9,
  parameter int unsigned VW            = 9,
  parameter int unsigned H_TOTAL       = 384,
  parameter int unsigned H_BLANK_START = 256,
  parameter int unsigned H_BLANK_END   = 0,
  parameter int unsigned H_SYNC_START  = 304,
  parameter int unsigned H_SYNC_END    = 336,
  parameter int unsigned V_TOTAL       = 264,
  parameter int unsigned V_BLANK_START = 224,
  parameter int unsigned V_BLANK_END   = 0,
  parameter int unsigned V_SYNC_START  = 240,
  parameter int unsigned V_SYNC_END    = 244,
  parameter int unsigned IRQ_LINE      = 224
) (
  input  logic          clk,
  input  logic          nRESET,
  output logic          pix_ce,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          csync_n,
  output logic          hblank,
  output logic          vblank,
  output logic          line_start,
  output logic          frame_start,
  output logic          irq_n,
  input  logic          intack_n
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] IRQ_V    = VW'(IRQ_LINE);

  generate
    if (64'(H_TOTAL) > (64'd1 << HW)) begin : g_h_range
      $error("video_timing_gen: H_TOTAL does not fit in HW bits");
    end
    if (64'(V_TOTAL) > (64'd1 << VW)) begin : g_v_range
      $error("video_timing_gen: V_TOTAL does not fit in VW bits");
    end
  endgenerate

  // Half-open window START <= c < END, wrapping when START > END, empty when equal.
  function automatic logic in_win(input logic [31:0] c, input logic [31:0] s,
                                  input logic [31:0] e);
    logic r;
    r = 1'b0;
    if (s < e)      r = (c >= s) && (c < e);
    else if (s > e) r = (c >= s) || (c < e);
    return r;
  endfunction

  localparam logic HS0 = in_win(32'd0, H_SYNC_START, H_SYNC_END);
  localparam logic VS0 = in_win(32'd0, V_SYNC_START, V_SYNC_END);
  localparam logic HB0 = in_win(32'd0, H_BLANK_START, H_BLANK_END);
  localparam logic VB0 = in_win(32'd0, V_BLANK_START, V_BLANK_END);

  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          h_wrap;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          hb_nxt;
  logic          vb_nxt;
  logic          irq_set;

  // Next counts and decodes; outputs register these so they stay aligned with the counts.
  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
    h_wrap  = (hcount == H_LAST);
    h_nxt   = h_wrap ? '0 : hcount + 1'b1;
    v_nxt   = vcount;
    if (h_wrap) v_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
    hs_nxt  = in_win(32'(h_nxt), H_SYNC_START, H_SYNC_END);
    vs_nxt  = in_win(32'(v_nxt), V_SYNC_START, V_SYNC_END);
    hb_nxt  = in_win(32'(h_nxt), H_BLANK_START, H_BLANK_END);
    vb_nxt  = in_win(32'(v_nxt), V_BLANK_START, V_BLANK_END);
    irq_set = pix_ce && h_wrap && (v_nxt == IRQ_V);
  end

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      div         <= '0;
      pix_ce      <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      hsync_n     <= ~HS0;
      vsync_n     <= ~VS0;
      csync_n     <= ~HS0 & ~VS0;
      hblank      <= HB0;
      vblank      <= VB0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      irq_n       <= 1'b1;
    end else begin
      div         <= div_nxt;
      pix_ce      <= (div_nxt == DIV_LAST);
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        hcount      <= h_nxt;
        vcount      <= v_nxt;
        hsync_n     <= ~hs_nxt;
        vsync_n     <= ~vs_nxt;
        csync_n     <= ~hs_nxt & ~vs_nxt;
        hblank      <= hb_nxt;
        vblank      <= vb_nxt;
        line_start  <= h_wrap;
        frame_start <= h_wrap && (v_nxt == '0);
      end
      // A set in the same clock as an acknowledge wins.
      if (irq_set)        irq_n <= 1'b0;
      else if (!intack_n) irq_n <= 1'b1;
    end
  end

endmodule
